// File: rtl/uart_tx_tick.sv
// uart_tx_tick: tick-paced UART transmitter (start, DATA_BITS LSB first, optional even parity, STOP_BITS stop)
// Ports: clk, rst (sync, active-high), tick (one pulse per bit period),
//   tx_data/tx_valid/tx_ready (accept handshake), txd (registered serial line), busy.
// Optional parity stage compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_tick #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
  logic r_par;
`else
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
`endif
  state_t               r_state;
  logic [DATA_BITS-1:0] r_sh;
  logic [2:0]           r_bcnt;
  logic                 r_scnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      r_sh     <= '0;
      r_bcnt   <= '0;
      r_scnt   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else if (r_state == IDLE) begin
      txd <= 1'b1;
      // tick is deliberately ignored here; SYNC waits for the next one
      if (tx_valid && tx_ready) begin
        r_sh     <= tx_data;
`ifdef UART_TX_PARITY_EN
        r_par    <= ^tx_data;
`endif
        tx_ready <= 1'b0;
        busy     <= 1'b1;
        r_state  <= SYNC;
      end
    end else if (tick) begin
      case (r_state)
        SYNC: begin
          txd     <= 1'b0;
          r_state <= START;
        end
        START: begin
          txd     <= r_sh[0];
          r_sh    <= r_sh >> 1;
          r_bcnt  <= '0;
          r_state <= DATA;
        end
        DATA: begin
          if (r_bcnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            txd     <= r_par;
            r_state <= PARITY;
`else
            txd     <= 1'b1;
            r_scnt  <= 1'b0;
            r_state <= STOP;
`endif
          end else begin
            txd    <= r_sh[0];
            r_sh   <= r_sh >> 1;
            r_bcnt <= r_bcnt + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          txd     <= 1'b1;
          r_scnt  <= 1'b0;
          r_state <= STOP;
        end
`endif
        STOP: begin
          if (r_scnt == 1'(STOP_BITS - 1)) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        default: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_tick.sv
// tb_uart_tx_tick: directed self-checking bench for uart_tx_tick (STOP_BITS=1 and STOP_BITS=2 instances)
module tb_uart_tx_tick;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic rdy0, txd0, busy0, rdy1, txd1, busy1;
  logic sel = 1'b0;
  logic w_txd, w_rdy, w_busy;
  int passed = 0, total = 0, tcnt = 0;
  assign w_txd  = sel ? txd1 : txd0;
  assign w_rdy  = sel ? rdy1 : rdy0;
  assign w_busy = sel ? busy1 : busy0;
  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(d0), .tx_valid(v0),
    .tx_ready(rdy0), .txd(txd0), .busy(busy0));
  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(d1), .tx_valid(v1),
    .tx_ready(rdy1), .txd(txd1), .busy(busy1));
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    tcnt = (tcnt == 8) ? 0 : tcnt + 1;
    tick = (tcnt == 8);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic next_tick(output int n, output bit stable);
    logic v;
    bit done;
    v = w_txd;
    n = 0;
    stable = 1'b1;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      n++;
      if (tick || n > 40) done = 1'b1;
      else begin
        #1;
        if (w_txd !== v) stable = 1'b0;
      end
    end
    #1;
  endtask
  task automatic send(input logic s, input logic [7:0] d, output logic tk);
    sel = s;
    if (s) begin d1 = d; v1 = 1'b1; end else begin d0 = d; v0 = 1'b1; end
    @(posedge clk);
    tk = tick;
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    if (s) d1 = ~d; else d0 = ~d;
    chk("acc busy", w_busy, 1);
    chk("acc rdy", w_rdy, 0);
    chk("acc txd", w_txd, 1);
  endtask
  task automatic check_frame(input string tag, input logic [7:0] d, input int nstop, input int sync_n);
    logic eb[$];
    int n;
    bit st;
    eb.push_back(1'b0);
    for (int i = 0; i < 8; i++) eb.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    eb.push_back(^d);
`endif
    for (int i = 0; i < nstop; i++) eb.push_back(1'b1);
    next_tick(n, st);
    if (sync_n > 0) chk({tag, " sync"}, n, sync_n);
    chk({tag, " start"}, w_txd, 0);
    chk({tag, " busy"}, w_busy, 1);
    for (int i = 1; i < eb.size(); i++) begin
      next_tick(n, st);
      chk($sformatf("%s w%0d", tag, i), n, 9);
      chk($sformatf("%s h%0d", tag, i), st, 1);
      chk($sformatf("%s b%0d", tag, i), w_txd, eb[i]);
      chk($sformatf("%s r%0d", tag, i), w_rdy, 0);
    end
    next_tick(n, st);
    chk({tag, " last w"}, n, 9);
    chk({tag, " last h"}, st, 1);
    chk({tag, " end rdy"}, w_rdy, 1);
    chk({tag, " end busy"}, w_busy, 0);
    chk({tag, " end txd"}, w_txd, 1);
  endtask
  initial begin
    int n;
    bit st;
    logic tk;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst txd0", txd0, 1);
      chk("rst rdy0", rdy0, 1);
      chk("rst busy0", busy0, 0);
      chk("rst txd1", txd1, 1);
      chk("rst busy1", busy1, 0);
    end
    rst = 1'b0;
    send(1'b0, 8'h55, tk);
    check_frame("x55", 8'h55, 1, 0);
    send(1'b0, 8'h01, tk);
    check_frame("x01", 8'h01, 1, 0);
    send(1'b0, 8'h03, tk);
    check_frame("x03", 8'h03, 1, 0);
    sel = 1'b0;
    d0 = 8'hA5;
    v0 = 1'b1;
    @(posedge clk);
    #1;
    d0 = 8'h3C;
    check_frame("b2b A5", 8'hA5, 1, 0);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    chk("b2b acc busy", busy0, 1);
    check_frame("b2b 3C", 8'h3C, 1, 8);
    send(1'b0, 8'hFF, tk);
    for (int i = 0; i < 6; i++) next_tick(n, st);
    chk("xFF bit4", txd0, 1);
    chk("xFF midbusy", busy0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort txd", txd0, 1);
    chk("abort busy", busy0, 0);
    chk("abort rdy", rdy0, 1);
    send(1'b0, 8'h00, tk);
    check_frame("x00", 8'h00, 1, 0);
    next_tick(n, st);
    repeat (8) @(posedge clk);
    #1;
    send(1'b1, 8'h96, tk);
    chk("align tick", tk, 1);
    check_frame("s2 x96", 8'h96, 2, 9);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
